vec_collector: RTL and testbench
================================

// Module: vec_collector
// PURPOSE
//  Receiver side of the vec_generator serial vector interface. Samples the 1-bit
//  vector stream after each start pulse and records the bit position of every '1'
//  (the sparse support of the LDGM row/column) in an internal FIFO. Downstream
//  signature logic pops the FIFO with a valid/ready handshake. Also reports the
//  Hamming weight and protocol errors.
// PARAMETERS
//  VEC_LEN   9800  max vector length in bits; positions 0..VEC_LEN-1
//  POS_W     14    position/weight width; must satisfy 2**POS_W >= VEC_LEN+1
//  FIFO_DEP  16    position FIFO depth, power of 2
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_b      in   1      asynchronous active-low reset
//  start      in   1      same pulse that drives vec_generator.start
//  vector     in   1      serial bit from vec_generator
//  finish     in   1      from vec_generator; high in the cycle carrying the last bit
//  pos_valid  out  1      FIFO not empty
//  pos_data   out  POS_W  head-of-FIFO bit position
//  pos_ready  in   1      downstream pop; pop occurs when pos_valid & pos_ready
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse: vector complete and FIFO drained
//  weight     out  POS_W  number of '1' bits in the last/current vector
//  err_ovf    out  1      sticky: a '1' was dropped because FIFO was full
//  err_len    out  1      sticky: VEC_LEN bits received without finish
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, bit counter 0, error flags cleared.
//  States: IDLE -> RECV -> DRAIN -> IDLE.
//  IDLE: start=1 -> RECV; clear bit counter, weight, err_ovf, err_len (FIFO kept).
//  RECV: first data bit is sampled the cycle AFTER start; one bit per cycle.
//   - vector=1: push current counter value, weight++ (saturate at 2**POS_W-1).
//   - push while full and no pop same cycle: bit dropped, err_ovf=1, weight still ++.
//   - push and pop same cycle while full: both succeed, no error.
//   - finish=1: that bit processed normally, then -> DRAIN.
//   - counter == VEC_LEN-1 with finish=0: bit processed, err_len=1, -> DRAIN.
//   - otherwise counter++.
//   - start=1 while in RECV or DRAIN: ignored (no restart, no flag).
//  DRAIN: stays until FIFO empty; then done=1 for exactly one cycle, -> IDLE.
//   If FIFO already empty on entry, done fires in the first DRAIN cycle.
//  FIFO: first-word fall-through; pos_data valid combinationally with pos_valid;
//   pos_data holds its value while pos_valid & !pos_ready. Popping empty: no effect.
//  Latency: a '1' sampled in cycle N is visible on pos_valid in cycle N+1.
//  weight updates live during RECV; holds until next accepted start.
//  Reset mid-operation: immediate return to reset values, FIFO contents lost.
// TESTING
//  1 Reset: rst_b=0 -> all outputs 0; release, no start -> stays IDLE, busy=0.
//  2 Pattern 0,1,1,0,1 (finish on 5th bit), pos_ready=1 -> pops 1,2,4; weight=3;
//    done one cycle after FIFO empty; busy returns 0.
//  3 Pair with vec_generator, idx=100 mode=0 then idx=9799 mode=1 -> popped
//    positions equal golden model support set; weight matches popcount.
//  4 pos_ready=0, 20 consecutive '1's, FIFO_DEP=16 -> 16 stored (0..15), err_ovf=1,
//    weight=20; then ready=1 -> pops 0..15, done.
//  5 Full FIFO, push+pop same cycle -> no err_ovf, order preserved.
//  6 VEC_LEN=8, no finish for 8 bits -> err_len=1, DRAIN, done; start in RECV
//    ignored; rst_b low mid-RECV -> FIFO empty, busy=0.

Source files
------------

// File: rtl/vec_collector.sv
// vec_collector: receiver for the vec_generator serial vector stream.
// After a start pulse, one bit is sampled per cycle (the first one in the cycle
// after start). The position of every '1' is pushed into a small first-word
// fall-through FIFO that downstream logic drains with a valid/ready handshake.
// The block also reports the Hamming weight and two sticky protocol errors.
//
// Ports:
//   clk        rising-edge clock
//   rst_b      asynchronous active-low reset
//   start      begins a vector (ignored unless idle)
//   vector     serial data bit
//   finish     marks the cycle carrying the last bit
//   pos_valid  FIFO not empty
//   pos_data   head-of-FIFO bit position
//   pos_ready  downstream accepts pos_data when pos_valid is high
//   busy       receiving or draining
//   done       one-cycle pulse: vector complete and FIFO drained
//   weight     count of '1' bits in the last/current vector (saturating)
//   err_ovf    sticky: a '1' was dropped because the FIFO was full
//   err_len    sticky: VEC_LEN bits arrived without finish
module vec_collector #(
  parameter int VEC_LEN  = 9800,
  parameter int POS_W    = 14,
  parameter int FIFO_DEP = 16    // power of 2, at least 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             vector,
  input  logic             finish,
  output logic             pos_valid,
  output logic [POS_W-1:0] pos_data,
  input  logic             pos_ready,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] weight,
  output logic             err_ovf,
  output logic             err_len
);

  localparam int AW = $clog2(FIFO_DEP);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(VEC_LEN - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEP);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] bit_cnt;

  logic [POS_W-1:0] mem [FIFO_DEP];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  logic empty, full, pop, push_req, push, drop, at_last;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = pos_valid & pos_ready;
  assign push_req = (state == RECV) & vector;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted; when full, wr_ptr equals rd_ptr and the head is read out
  // combinationally before the write lands at the clock edge.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign at_last  = (bit_cnt == LAST_POS);

  assign pos_valid = ~empty;
  assign pos_data  = empty ? '0 : mem[rd_ptr];
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RECV;
      RECV:  if (finish || at_last) state_nxt = DRAIN;
      DRAIN: if (empty) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      bit_cnt <= '0;
      weight  <= '0;
      err_ovf <= 1'b0;
      err_len <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        bit_cnt <= '0;
        weight  <= '0;
        err_ovf <= 1'b0;
        err_len <= 1'b0;
      end else if (state == RECV) begin
        if (vector && weight != '1) weight <= weight + 1'b1;
        if (drop) err_ovf <= 1'b1;
        if (!finish) begin
          if (at_last) err_len <= 1'b1;
          else         bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bit_cnt;
  end

endmodule

// File: tb/tb_vec_collector.sv
module tb_vec_collector;
  localparam int VL  = 40;
  localparam int PW  = 6;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst_b, start, vector, finish, pos_ready;
  logic          pos_valid, busy, done, err_ovf, err_len;
  logic [PW-1:0] pos_data, weight;

  int checks = 0;
  int errors = 0;

  // Reference model: expected popped positions in order, plus FIFO occupancy.
  int exp_q[$];
  int occ;
  int exp_w;
  int exp_ovf, exp_len;

  always #5 clk = ~clk;

  vec_collector #(.VEC_LEN(VL), .POS_W(PW), .FIFO_DEP(DEP)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .vector(vector), .finish(finish),
    .pos_valid(pos_valid), .pos_data(pos_data), .pos_ready(pos_ready),
    .busy(busy), .done(done), .weight(weight), .err_ovf(err_ovf), .err_len(err_len)
  );

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && pos_valid === 1'b1 && pos_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0d expected none", pos_data);
      end else begin
        check("pop_data", int'(pos_data), exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; the model decides pop/accept/drop from occupancy.
  task automatic step(input logic v, input logic f, input logic s, input logic r,
                      input int pos, input int exp_busy, input int exp_done);
    int pop_m, acc;
    vector = v; finish = f; start = s; pos_ready = r;
    pop_m = (r && occ > 0) ? 1 : 0;
    acc   = (v && (occ < DEP || pop_m == 1)) ? 1 : 0;
    if (v && acc == 0) exp_ovf = 1;
    if (acc == 1) exp_q.push_back(pos);
    @(negedge clk);
    check("pos_valid", int'(pos_valid), (occ > 0) ? 1 : 0);
    check("busy", int'(busy), exp_busy);
    check("done", int'(done), exp_done);
    occ = occ - pop_m + acc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input logic [VL-1:0] bv, input logic [VL-1:0] rv,
                            input int len, input bit use_fin);
    bit fin_ok;
    step(1'b0, 1'b0, 1'b1, 1'($urandom % 2), 0, 0, 0);
    exp_w = 0; exp_ovf = 0; exp_len = use_fin ? 0 : 1;
    for (int k = 0; k < len; k++) begin
      step(bv[k], 1'(use_fin && k == len - 1), 1'(($urandom % 6) == 0), rv[k], k, 1, 0);
      if (bv[k]) exp_w = (exp_w < (1 << PW) - 1) ? exp_w + 1 : exp_w;
    end
    fin_ok = 1'b0;
    for (int i = 0; i < 300 && !fin_ok; i++) begin
      int ed;
      ed = (occ == 0) ? 1 : 0;
      step(1'b0, 1'b0, 1'(($urandom % 4) == 0), 1'((i > 60) || ($urandom % 2 == 1)), 0, 1, ed);
      if (ed == 1) fin_ok = 1'b1;
    end
    if (!fin_ok) check("drain_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("weight", int'(weight), exp_w);
    check("err_ovf", int'(err_ovf), exp_ovf);
    check("err_len", int'(err_len), exp_len);
    check("queue_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [VL-1:0] bv, rv;
    int len;
    bit fin;

    rst_b = 1'b0; start = 1'b0; vector = 1'b0; finish = 1'b0; pos_ready = 1'b0;
    occ = 0; exp_w = 0; exp_ovf = 0; exp_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_pos_data", int'(pos_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_weight", int'(weight), 0);
    check("rst_err_ovf", int'(err_ovf), 0);
    check("rst_err_len", int'(err_len), 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);

    // 0,1,1,0,1 with finish on the fifth bit
    bv = '0; bv[4:0] = 5'b10110; rv = '1;
    run_vector(bv, rv, 5, 1'b1);

    // 20 ones with no pops: 16 stored, 4 dropped
    bv = '0; bv[19:0] = '1; rv = '0;
    run_vector(bv, rv, 20, 1'b1);

    // fill the FIFO, then push and pop together while full
    bv = '0; bv[17:0] = '1; rv = '0; rv[17:16] = 2'b11;
    run_vector(bv, rv, 18, 1'b1);

    // full length without finish, then full length with finish on the last bit
    bv = VL'({$urandom(), $urandom()}); rv = VL'({$urandom(), $urandom()});
    run_vector(bv, rv, VL, 1'b0);
    bv = VL'({$urandom(), $urandom()}); rv = '1;
    run_vector(bv, rv, VL, 1'b1);

    for (int n = 0; n < 30; n++) begin
      fin = ($urandom % 5) != 0;
      len = fin ? $urandom_range(1, VL) : VL;
      bv = VL'({$urandom(), $urandom()});
      if ($urandom % 2 == 1) bv = bv & VL'({$urandom(), $urandom()});
      case ($urandom % 4)
        0: rv = '1;
        1: rv = '0;
        2: rv = VL'({$urandom(), $urandom()});
        default: rv = VL'({$urandom(), $urandom()}) & VL'({$urandom(), $urandom()});
      endcase
      run_vector(bv, rv, len, fin);
    end

    // reset in the middle of a vector
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    exp_ovf = 0;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b0, k, 1, 0);
    rst_b = 1'b0;
    #1;
    check("midrst_pos_valid", int'(pos_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_weight", int'(weight), 0);
    exp_q.delete();
    occ = 0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    bv = '0; bv[4:0] = 5'b10110; rv = '1;
    run_vector(bv, rv, 5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
